alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational 8-bit ALU between NUM_REQ requesters, e.g. the execute stage and the branch-compare path.
- Accepts one request at a time through a valid/ready handshake, with round-robin grant.
- Drives the ALU from registered operands, captures result and flags, and returns them to the owning requester through a valid/ready response channel.
- Sits between the requesters and the ALU instance. It owns every ALU input port.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IDW, $clog2(NUM_REQ) (minimum 1), width of the owner index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted; one-hot or zero.
- req_op1  in  NUM_REQ x 8  per-requester operand 1.
- req_op2  in  NUM_REQ x 8  per-requester operand 2.
- req_aluop  in  NUM_REQ x 3  per-requester ALU opcode.
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  8  captured ALU result, shared by all requesters.
- rsp_equal  out  1  captured equal flag.
- rsp_lessthan  out  1  captured lessThan flag.
- alu_control  out  1  ALU control_in; constant 0 (logic/arith mode).
- alu_op1  out  8  ALU operand 1.
- alu_op2  out  8  ALU operand 2.
- alu_aluop  out  3  ALU opcode.
- alu_result  in  8  ALU result.
- alu_equal  in  1  ALU equal flag.
- alu_lessthan  in  1  ALU lessThan flag.

Behaviour:
- One clock (clk). reset is synchronous and active-high and takes priority over all other state updates.
- FSM states are IDLE, EXEC and RESP. Reset forces:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - Operand/opcode registers = 0; rsp_result/rsp_equal/rsp_lessthan = 0.
  - req_ready = 0, rsp_valid = 0.
  - alu_op1/alu_op2/alu_aluop = 0 (registered sources), alu_control = 0.
- IDLE:
  - Grant = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally in the same cycle; all other req_ready bits = 0.
  - On grant: latch op1/op2/aluop, owner = grant, rr_ptr = (grant+1) mod NUM_REQ, next state EXEC.
  - No valid: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - ALU inputs come from the latched registers.
  - Capture alu_result/alu_equal/alu_lessthan into the rsp registers. Next state RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid[owner] = 1; all other rsp_valid bits = 0.
  - Hold the rsp registers stable.
  - When rsp_ready[owner] = 1, next state IDLE. rsp_ready on non-owner bits is ignored.
  - A new grant cannot occur in the RESP cycle. Minimum issue interval is 3 cycles.
- Latency: handshake at cycle N, capture at N+1, rsp_valid at N+2.
- The ALU inputs change only on the IDLE grant edge, so they are stable for the entire EXEC cycle.
- Requesters must hold valid and payload until ready. A non-granted requester keeps waiting; its payload is not sampled.
- Flags and result are stored verbatim from the ALU:
  - Compare ops (101/110/111) return result = 0.
  - Logic/arith ops return equal = lessthan = 0.
  - ADD/SUB wrap modulo 256.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response, the FSM goes to IDLE, and rr_ptr returns to 0.
- All requesters valid continuously: grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- rr_ptr wrap: with rr_ptr = NUM_REQ-1 and only requester 0 valid, requester 0 is granted and rr_ptr becomes 1.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum: AND=000, OR=001, XOR=010, ADD=011, SUB=100, SLT=101, SLTE=110, EQ=111.
  - arb_state_e enum: IDLE, EXEC, RESP.
  - ALU_W = 8 constant.
- One sub-module: rr_picker. It is combinational, takes valid[NUM_REQ] and ptr[IDW], and outputs grant index plus a grant_any flag. It is reused by future shared-resource arbiters.

Test Plan:
- Reset, then req0 ADD op1=8'h7F op2=8'h01. Required:
  - req_ready[0] in the same cycle.
  - rsp_valid[0] two cycles later with rsp_result=8'h80, equal=0, lessthan=0.
  - rsp_ready held 0 for 3 cycles: response is held stable, no new grant.
- req0 and req1 valid in the same cycle, from reset (rr_ptr=0). req0 is SUB 8'h05-8'h07; req1 is EQ 8'h3C,8'h3C. Required:
  - req0 is served first with result 8'hFE.
  - req1 is then served with result 0, equal=1.
  - The second grant occurs in the first IDLE cycle after the req0 response handshake.
- Both requesters continuously valid for 6 transactions. Grant order is 0,1,0,1,0,1. rsp_valid is never asserted to the non-owner.
- req1 SLTE op1=8'h10 op2=8'h10 with rr_ptr=1. Required: rsp lessthan=1, equal=1, result=0. rsp_ready asserted on the non-owner bit only is ignored.
- reset asserted during EXEC of req0 AND 8'hF0&8'h3C. Required: no rsp_valid appears, outputs return to their reset values, and the next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and its ALU interface.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    AND  = 3'b000,
    OR   = 3'b001,
    XOR  = 3'b010,
    ADD  = 3'b011,
    SUB  = 3'b100,
    SLT  = 3'b101,
    SLTE = 3'b110,
    EQ   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or above ptr,
// wrapping modulo NUM_REQ. Shared by the resource arbiters.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     grant,
  output logic               grant_any
);

  // Scan from farthest to nearest so the nearest valid index wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[IDW'((int'(ptr) + k) % NUM_REQ)]) begin
        grant     = IDW'((int'(ptr) + k) % NUM_REQ);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ
// requesters: grant in IDLE, execute from registered operands, hold response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]   req_op1,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]   req_op2,
  input  logic [NUM_REQ-1:0][2:0]         req_aluop,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [ALU_W-1:0]                rsp_result,
  output logic                            rsp_equal,
  output logic                            rsp_lessthan,
  output logic                            alu_control,
  output logic [ALU_W-1:0]                alu_op1,
  output logic [ALU_W-1:0]                alu_op2,
  output logic [2:0]                      alu_aluop,
  input  logic [ALU_W-1:0]                alu_result,
  input  logic                            alu_equal,
  input  logic                            alu_lessthan
);

  arb_state_e          state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [ALU_W-1:0]    op1_q, op1_d, op2_q, op2_d;
  alu_op_e             aluop_q, aluop_d;
  logic [ALU_W-1:0]    result_q, result_d;
  logic                equal_q, equal_d, lt_q, lt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]      grant;
  logic                grant_any;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    aluop_d     = aluop_q;
    result_d    = result_q;
    equal_d     = equal_q;
    lt_d        = lt_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready = NUM_REQ'(1) << grant;
          op1_d     = req_op1[grant];
          op2_d     = req_op2[grant];
          aluop_d   = alu_op_e'(req_aluop[grant]);
          owner_d   = grant;
          rr_ptr_d  = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // ALU inputs have been stable since the grant edge; capture now.
        result_d    = alu_result;
        equal_d     = alu_equal;
        lt_d        = alu_lessthan;
        rsp_valid_d = NUM_REQ'(1) << owner_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      aluop_q     <= AND;
      result_q    <= '0;
      equal_q     <= 1'b0;
      lt_q        <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      aluop_q     <= aluop_d;
      result_q    <= result_d;
      equal_q     <= equal_d;
      lt_q        <= lt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = result_q;
  assign rsp_equal    = equal_q;
  assign rsp_lessthan = lt_q;
  assign alu_control  = 1'b0;
  assign alu_op1      = op1_q;
  assign alu_op2      = op2_q;
  assign alu_aluop    = aluop_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against
// a transaction-level round-robin / ALU reference model.
module tb_alu_arbiter;
  localparam int N = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][7:0]  req_op1, req_op2;
  logic [N-1:0][2:0]  req_aluop;
  logic [7:0]         rsp_result;
  logic               rsp_equal, rsp_lessthan, alu_control;
  logic [7:0]         alu_op1, alu_op2, alu_result;
  logic [2:0]         alu_aluop;
  logic               alu_equal, alu_lessthan;

  int checks   = 0;
  int failures = 0;
  int exp_ptr  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_aluop(req_aluop),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_equal(rsp_equal), .rsp_lessthan(rsp_lessthan),
    .alu_control(alu_control), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_aluop(alu_aluop), .alu_result(alu_result), .alu_equal(alu_equal),
    .alu_lessthan(alu_lessthan)
  );

  // Behavioural ALU: returns {result, equal, lessthan}.
  function automatic logic [9:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return {a & b, 2'b00};
      3'd1:    return {a | b, 2'b00};
      3'd2:    return {a ^ b, 2'b00};
      3'd3:    return {8'(a + b), 2'b00};
      3'd4:    return {8'(a - b), 2'b00};
      3'd5:    return {8'h00, a == b, a < b};
      3'd6:    return {8'h00, a == b, a <= b};
      default: return {8'h00, a == b, 1'b0};
    endcase
  endfunction

  always_comb {alu_result, alu_equal, alu_lessthan} = alu_ref(alu_aluop, alu_op1, alu_op2);

  function automatic int pick(input logic [N-1:0] m, input int ptr);
    int mi;
    mi = int'(m);
    for (int k = 0; k < N; k++)
      if (((mi >> ((ptr + k) % N)) & 1) == 1) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    req_op1[i]   = a;
    req_op2[i]   = b;
    req_aluop[i] = op;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},  32'(req_ready), 32'(0));
    check({tag, "_rspv"}, 32'(rsp_valid), 32'(0));
    check({tag, "_res"},  32'({rsp_result, rsp_equal, rsp_lessthan}), 32'(0));
    check({tag, "_alu"},  32'({alu_control, alu_op1, alu_op2, alu_aluop}), 32'(0));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    step();
    step();
    check_reset_vals("reset");
    reset   = 1'b0;
    exp_ptr = 0;
  endtask

  // One full transaction from the current IDLE slot to the response handshake.
  task automatic run_txn(input int hold, input bit keep_valid, input bit poke,
                         output int g, output logic [7:0] res, output logic eq,
                         output logic lt);
    logic [9:0]   e;
    logic [7:0]   a, b;
    logic [2:0]   op;
    logic [N-1:0] oh;
    #1;
    g = pick(req_valid, exp_ptr);
    res = '0; eq = 1'b0; lt = 1'b0;
    if (g < 0) begin
      check("grant_none", 32'(req_ready), 32'(0));
      return;
    end
    oh = N'(1) << g;
    check("grant", 32'(req_ready), 32'(oh));
    a  = req_op1[g];
    b  = req_op2[g];
    op = req_aluop[g];
    e  = alu_ref(op, a, b);
    exp_ptr = (g + 1) % N;
    step();
    if (keep_valid) rand_req(g);
    else req_valid[g] = 1'b0;
    #1;
    check("exec_rdy",  32'(req_ready), 32'(0));
    check("exec_rspv", 32'(rsp_valid), 32'(0));
    check("exec_alu",  32'({alu_control, alu_op1, alu_op2, alu_aluop}), 32'({1'b0, a, b, op}));
    step();
    check("rsp_v",   32'(rsp_valid), 32'(oh));
    check("rsp_out", 32'({rsp_result, rsp_equal, rsp_lessthan}), 32'(e));
    check("rsp_rdy", 32'(req_ready), 32'(0));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = poke ? ~oh : '0;
      step();
      check("hold_v",   32'(rsp_valid), 32'(oh));
      check("hold_out", 32'({rsp_result, rsp_equal, rsp_lessthan}), 32'(e));
      check("hold_rdy", 32'(req_ready), 32'(0));
    end
    res = rsp_result; eq = rsp_equal; lt = rsp_lessthan;
    rsp_ready = oh;
    step();
    rsp_ready = '0;
    check("rsp_drop", 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    int g;
    logic [7:0] res;
    logic eq, lt;
    logic [N-1:0] pend;

    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    req_op1 = '0; req_op2 = '0; req_aluop = '0;

    // ADD wrap-free overflow into bit 7, response held 3 cycles.
    do_reset();
    set_req(0, 3'd3, 8'h7F, 8'h01);
    req_valid = 2'b01;
    run_txn(3, 1'b0, 1'b0, g, res, eq, lt);
    check("add_res", 32'({res, eq, lt}), 32'({8'h80, 2'b00}));

    // Simultaneous requests from reset: req0 SUB first, then req1 EQ.
    do_reset();
    set_req(0, 3'd4, 8'h05, 8'h07);
    set_req(1, 3'd7, 8'h3C, 8'h3C);
    req_valid = 2'b11;
    run_txn(1, 1'b0, 1'b0, g, res, eq, lt);
    check("sub_owner", 32'(g), 32'(0));
    check("sub_res", 32'({res, eq, lt}), 32'({8'hFE, 2'b00}));
    run_txn(0, 1'b0, 1'b0, g, res, eq, lt);
    check("eq_owner", 32'(g), 32'(1));
    check("eq_res", 32'({res, eq, lt}), 32'({8'h00, 2'b10}));

    // Both continuously valid: rotation 0,1,0,1,0,1.
    rand_req(0); rand_req(1);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      run_txn(k % 2, 1'b1, 1'b1, g, res, eq, lt);
      check("rot_order", 32'(g), 32'(k % 2));
    end
    req_valid = '0;

    // Move rr_ptr to 1, then req1 SLTE with non-owner rsp_ready poked.
    rand_req(0); req_valid = 2'b01;
    run_txn(0, 1'b0, 1'b0, g, res, eq, lt);
    set_req(1, 3'd6, 8'h10, 8'h10);
    req_valid = 2'b10;
    run_txn(2, 1'b0, 1'b1, g, res, eq, lt);
    check("slte_res", 32'({res, eq, lt}), 32'({8'h00, 2'b11}));

    // rr_ptr wrap: ptr=1, only req0 valid, then both valid must pick req1.
    rand_req(0); req_valid = 2'b01;
    run_txn(0, 1'b0, 1'b0, g, res, eq, lt);
    rand_req(0); req_valid = 2'b01;
    run_txn(0, 1'b0, 1'b0, g, res, eq, lt);
    check("wrap_owner", 32'(g), 32'(0));
    rand_req(0); rand_req(1); req_valid = 2'b11;
    run_txn(0, 1'b0, 1'b0, g, res, eq, lt);
    check("after_wrap", 32'(g), 32'(1));
    req_valid = '0;

    // Reset during EXEC drops the transaction and clears rr_ptr.
    step();
    set_req(0, 3'd0, 8'hF0, 8'h3C);
    req_valid = 2'b01;
    #1;
    check("midrst_grant", 32'(req_ready), 32'(1));
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    check_reset_vals("midrst");
    step();
    check("midrst_norsp", 32'(rsp_valid), 32'(0));
    reset = 1'b0;
    exp_ptr = 0;
    rand_req(0); rand_req(1); req_valid = 2'b11;
    run_txn(0, 1'b0, 1'b0, g, res, eq, lt);
    check("midrst_next", 32'(g), 32'(0));
    req_valid = '0;

    // Randomized traffic; pending requesters hold valid and payload.
    pend = '0;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          rand_req(i);
        end
      req_valid = pend;
      if (pend == '0) begin
        #1;
        check("rand_idle", 32'(req_ready), 32'(0));
        step();
      end else begin
        run_txn(int'($urandom_range(0, 2)), 1'b0, 1'(bit'($urandom_range(0, 1))),
                g, res, eq, lt);
        pend = req_valid;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
